// File: rtl/alu_op_sequencer.sv
// Start/busy/done sequencer around a shared 4-bit adder and bitwise unit.
// Define ALU_MUL_SEQ_EN to build the 4-step shift-add multiply for opcode 110.
module alu_op_sequencer #(
    parameter int WIDTH = 4
`ifdef ALU_MUL_SEQ_EN
    ,
    parameter int MUL_STEPS = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               err
);

    typedef enum logic [1:0] {
        Idle,
        Exec,
        Mul,
        Done
    } stateT;

    localparam logic [2:0] OpNegA = 3'd0;
    localparam logic [2:0] OpNegB = 3'd1;
    localparam logic [2:0] OpAdd  = 3'd2;
    localparam logic [2:0] OpSub  = 3'd3;
    localparam logic [2:0] OpAnd  = 3'd4;
    localparam logic [2:0] OpOr   = 3'd5;

    stateT state;
    stateT stateNext;

    logic [2:0]       opR;
    logic [WIDTH-1:0] aR;
    logic [WIDTH-1:0] bR;
    logic [WIDTH-1:0] addX;
    logic [WIDTH-1:0] addY;
    logic             addCin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] andV;
    logic [WIDTH-1:0] orV;

`ifdef ALU_MUL_SEQ_EN
    localparam logic [2:0] OpMul = 3'd6;
    localparam int CntW = $clog2(MUL_STEPS);

    // acc = {partial high half, multiplier bits still to consume}
    logic [CntW-1:0]    cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic               lastStep;

    assign accNext  = {sum, acc[WIDTH-1:1]};
    assign lastStep = (cnt == CntW'(MUL_STEPS - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= Idle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            Idle: begin
                if (start) begin
                    stateNext = Exec;
`ifdef ALU_MUL_SEQ_EN
                    if (op == OpMul) begin
                        stateNext = Mul;
                    end
`endif
                end
            end
            Exec: stateNext = Done;
`ifdef ALU_MUL_SEQ_EN
            Mul: begin
                if (lastStep) begin
                    stateNext = Done;
                end
            end
`endif
            Done: stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end

    always_comb begin
        busy = (state != Idle);
        done = (state == Done);
    end

    // One adder serves negate, add, subtract and every multiply step.
    always_comb begin
        addX   = '0;
        addY   = '0;
        addCin = 1'b0;
        case (opR)
            OpNegA: begin
                addX   = ~aR;
                addCin = 1'b1;
            end
            OpNegB: begin
                addX   = ~bR;
                addCin = 1'b1;
            end
            OpAdd: begin
                addX = aR;
                addY = bR;
            end
            OpSub: begin
                addX   = aR;
                addY   = ~bR;
                addCin = 1'b1;
            end
            default: ;
        endcase
`ifdef ALU_MUL_SEQ_EN
        if (state == Mul) begin
            addX   = acc[2*WIDTH-1:WIDTH];
            addY   = acc[0] ? aR : '0;
            addCin = 1'b0;
        end
`endif
        sum  = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
        andV = aR & bR;
        orV  = aR | bR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opR    <= '0;
            aR     <= '0;
            bR     <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_MUL_SEQ_EN
            cnt    <= '0;
            acc    <= '0;
`endif
        end else begin
            case (state)
                Idle: begin
                    if (start) begin
                        opR <= op;
                        aR  <= a;
                        bR  <= b;
`ifdef ALU_MUL_SEQ_EN
                        cnt <= '0;
                        acc <= {{WIDTH{1'b0}}, b};
`endif
                    end
                end
                Exec: begin
                    err   <= 1'b0;
                    carry <= 1'b0;
                    case (opR)
                        OpNegA, OpNegB, OpAdd, OpSub: begin
                            result <= {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                            carry  <= sum[WIDTH];
                            zero   <= (sum[WIDTH-1:0] == '0);
                        end
                        OpAnd: begin
                            result <= {{WIDTH{1'b0}}, andV};
                            zero   <= (andV == '0);
                        end
                        OpOr: begin
                            result <= {{WIDTH{1'b0}}, orV};
                            zero   <= (orV == '0);
                        end
                        default: begin
                            result <= '0;
                            zero   <= 1'b1;
                            err    <= 1'b1;
                        end
                    endcase
                end
`ifdef ALU_MUL_SEQ_EN
                Mul: begin
                    acc <= accNext;
                    cnt <= cnt + 1'b1;
                    if (lastStep) begin
                        result <= accNext;
                        carry  <= 1'b0;
                        zero   <= (accNext == '0);
                        err    <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer against an arithmetic reference model.
// Builds with or without ALU_MUL_SEQ_EN; expectations follow the same macro.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       err;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .carry(carry),
        .zero(zero),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {err, zero, carry, result[7:0]} from the opcode rules.
    function automatic logic [10:0] model(input logic [2:0] o,
                                          input logic [3:0] x,
                                          input logic [3:0] y);
        int r;
        bit c;
        bit e;
        r = 0;
        c = 1'b0;
        e = 1'b0;
        case (o)
            3'd0: begin
                r = (16 - int'(x)) % 16;
                c = (x == 4'd0);
            end
            3'd1: begin
                r = (16 - int'(y)) % 16;
                c = (y == 4'd0);
            end
            3'd2: begin
                r = int'(x) + int'(y);
                c = (r > 15);
                r = r % 16;
            end
            3'd3: begin
                c = (x >= y);
                r = (int'(x) - int'(y) + 16) % 16;
            end
            3'd4: r = int'(x & y);
            3'd5: r = int'(x | y);
`ifdef ALU_MUL_SEQ_EN
            3'd6: r = int'(x) * int'(y);
`else
            3'd6: e = 1'b1;
`endif
            default: e = 1'b1;
        endcase
        return {e, (r == 0), c, 8'(r)};
    endfunction

    function automatic int latency(input logic [2:0] o);
`ifdef ALU_MUL_SEQ_EN
        return (o == 3'd6) ? 5 : 2;
`else
        return (o == 3'd6) ? 2 : 2;
`endif
    endfunction

    // Called at a sample point with the DUT idle; returns idle.
    task automatic doOp(input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y, input bit noisy,
                        input string tag);
        logic [10:0] e;
        int          lat;
        int          bc;
        int          extra;
        int          l;
        e = model(o, x, y);
        l = latency(o);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        step();
        start = 1'b0;
        lat = -1;
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (noisy) begin
                start = 1'b1;
                op = 3'($urandom);
                a = 4'($urandom);
                b = 4'($urandom);
            end else begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            step();
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'(l - 1));
        chk({tag, ".busyCycles"}, 32'(bc), 32'(l));
        chk({tag, ".outputs"}, {21'd0, err, zero, carry, result}, {21'd0, e});
        step();
        chk({tag, ".pulseEnd"}, {30'd0, busy, done}, 32'd0);
        extra = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (done !== 1'b0) extra++;
        end
        chk({tag, ".noExtraDone"}, 32'(extra), 32'd0);
        chk({tag, ".hold"}, {21'd0, err, zero, carry, result}, {21'd0, e});
    endtask

    initial begin
        int s1;
        int s2;
        int nd;
        logic [2:0] ro;

        reset = 1'b1;
        start = 1'b1;
        op = 3'd2;
        a = 4'd7;
        b = 4'd7;
        step();
        step();
        step();
        chk("reset.outputs", {20'd0, busy, done, err, zero, carry, result}, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        step();
        chk("reset.idle", {20'd0, busy, done, err, zero, carry, result}, 32'd0);

        doOp(3'd2, 4'd9, 4'd8, 1'b0, "add9_8");
        doOp(3'd3, 4'd3, 4'd5, 1'b0, "sub3_5");
        doOp(3'd3, 4'd5, 4'd5, 1'b0, "sub5_5");
        doOp(3'd6, 4'd15, 4'd15, 1'b0, "mul15_15");
        doOp(3'd6, 4'd0, 4'd7, 1'b0, "mul0_7");
        doOp(3'd0, 4'd0, 4'd3, 1'b0, "nega0");
        doOp(3'd1, 4'd9, 4'd1, 1'b0, "negb1");
        doOp(3'd4, 4'hC, 4'h3, 1'b0, "and");
        doOp(3'd7, 4'd3, 4'd3, 1'b0, "op111");
        doOp(3'd6, 4'd3, 4'd3, 1'b0, "op110");

        // start pulsed while busy must be ignored
        doOp(3'd2, 4'd1, 4'd1, 1'b1, "busyStart");
        doOp(3'd4, 4'hF, 4'h6, 1'b0, "afterBusy");

        // start held high: back-to-back with one idle cycle between
        start = 1'b1;
        op = 3'd5;
        a = 4'd3;
        b = 4'd4;
        s1 = -1;
        s2 = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done === 1'b1) begin
                if (s1 < 0) s1 = k;
                else if (s2 < 0) s2 = k;
            end
        end
        start = 1'b0;
        chk("b2b.first", 32'(s1), 32'd1);
        chk("b2b.second", 32'(s2), 32'd4);
        chk("b2b.result", {24'd0, result}, 32'h07);
        step();
        step();
        step();

        // reset in the second multiply cycle aborts the op
        start = 1'b1;
        op = 3'd6;
        a = 4'd6;
        b = 4'd5;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("abort.outputs", {20'd0, busy, done, err, zero, carry, result}, 32'd0);
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done !== 1'b0) nd++;
        end
        chk("abort.noDone", 32'(nd), 32'd0);
        doOp(3'd5, 4'hA, 4'h5, 1'b0, "orAfterAbort");

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            doOp(ro, 4'($urandom), 4'($urandom), 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
